reg_bank_seq: RTL and testbench

REG_BANK_SEQ -- requirements
Module: reg_bank_seq

---
 rtl/reg_bank_seq.sv | 147 ++++++++++++++
 tb/tb_reg_bank_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_seq.sv
// reg_bank_seq: pushbutton-stepped sequencer writing a 4x4-bit register bank.
// Define STEP_DEBOUNCE_EN to add a 2^DB_BITS-cycle stability filter on the button.
module reg_bank_seq #(
    parameter int unsigned DB_BITS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [3:0] instr,
    input  logic [3:0] data_path,
    output logic [1:0] select,
    output logic [3:0] r0,
    output logic [3:0] r1,
    output logic [3:0] r2,
    output logic [3:0] r3,
    output logic       busy,
    output logic [3:0] wr_count
);

    if (DB_BITS < 1) begin : g_db_check
        $error("DB_BITS must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, WAIT_REL} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [1:0]      rdy_q;
    logic            armed_q, armed_d;
    logic            prev_q;
    logic            rise_q, rise_d;
    logic            step_s;
    logic [3:0]      ir_q, ir_d;
    logic [1:0]      select_q, select_d;
    logic [3:0][3:0] regs_q, regs_d;
    logic [3:0]      wr_count_q, wr_count_d;
    logic            busy_q, busy_d;

    // rdy_q marks when sync2_q holds a real post-reset sample of the button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            rdy_q   <= '0;
        end else begin
            sync1_q <= step;
            sync2_q <= sync1_q;
            rdy_q   <= {rdy_q[0], 1'b1};
        end
    end

`ifdef STEP_DEBOUNCE_EN
    logic [DB_BITS-1:0] db_cnt_q, db_cnt_d;
    logic               db_q, db_d;

    always_comb begin
        db_cnt_d = '0;
        db_d     = db_q;
        if (sync2_q != db_q) begin
            if (db_cnt_q == '1) db_d = sync2_q;
            else                db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            db_q     <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            db_q     <= db_d;
        end
    end

    assign step_s = db_q;
`else
    assign step_s = sync2_q;
`endif

    // A press held through reset release never arms the edge detector;
    // arming needs a genuinely sampled released button first.
    always_comb begin
        armed_d = armed_q | (rdy_q[1] & ~sync2_q);
        rise_d  = step_s & ~prev_q & armed_q;
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        select_d   = select_q;
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        case (state_q)
            IDLE: begin
                if (rise_q) begin
                    ir_d     = instr;
                    select_d = instr[3:2];
                    state_d  = FETCH;
                end
            end
            FETCH: state_d = WRITE;
            WRITE: begin
                regs_d[ir_q[1:0]] = data_path;
                wr_count_d        = wr_count_q + 4'h1;
                state_d           = WAIT_REL;
            end
            WAIT_REL: begin
                if (!step_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            prev_q     <= 1'b0;
            rise_q     <= 1'b0;
            ir_q       <= '0;
            select_q   <= '0;
            regs_q     <= '0;
            wr_count_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            prev_q     <= step_s;
            rise_q     <= rise_d;
            ir_q       <= ir_d;
            select_q   <= select_d;
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
            busy_q     <= busy_d;
        end
    end

    assign select   = select_q;
    assign r0       = regs_q[0];
    assign r1       = regs_q[1];
    assign r2       = regs_q[2];
    assign r3       = regs_q[3];
    assign busy     = busy_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_bank_seq.sv
// Directed self-checking bench for reg_bank_seq (both STEP_DEBOUNCE_EN builds).
module tb_reg_bank_seq;

`ifdef STEP_DEBOUNCE_EN
    localparam int HOLD   = 24;
    localparam int SETTLE = 40;
`else
    localparam int HOLD   = 4;
    localparam int SETTLE = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step = 1'b0;
    logic [3:0] instr = '0;
    logic [3:0] dp_val = '0;
    logic       fb_mode = 1'b0;
    logic [3:0] data_path;
    logic [1:0] select;
    logic [3:0] r0, r1, r2, r3;
    logic       busy;
    logic [3:0] wr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External source mux: select 2'b10 routes r3+1 when feedback is enabled
    always_comb begin
        data_path = dp_val;
        if (fb_mode && select == 2'b10) data_path = r3 + 4'h1;
    end

    reg_bank_seq #(.DB_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .step(step), .instr(instr),
        .data_path(data_path), .select(select), .r0(r0), .r1(r1),
        .r2(r2), .r3(r3), .busy(busy), .wr_count(wr_count)
    );

    task automatic press(input logic [3:0] ins, input logic [3:0] dp);
        @(negedge clk);
        instr  = ins;
        dp_val = dp;
        step   = 1'b1;
        repeat (HOLD) @(negedge clk);
        step = 1'b0;
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({r0, r1, r2, r3} !== 16'h0) begin errors++; $display("FAIL reset_regs got %h exp 0000", {r0, r1, r2, r3}); end
        checks++; if (select !== 2'b00) begin errors++; $display("FAIL reset_select got %b exp 00", select); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (wr_count !== 4'h0) begin errors++; $display("FAIL reset_wrcount got %h exp 0", wr_count); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        press(4'b0110, 4'h9);
        checks++; if (r2 !== 4'h9) begin errors++; $display("FAIL basic_r2 got %h exp 9", r2); end
        checks++; if (select !== 2'b01) begin errors++; $display("FAIL basic_select got %b exp 01", select); end
        checks++; if (wr_count !== 4'h1) begin errors++; $display("FAIL basic_wrcount got %h exp 1", wr_count); end
        checks++; if ({r0, r1, r3} !== 12'h0) begin errors++; $display("FAIL basic_others got %h exp 000", {r0, r1, r3}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", busy); end
    endtask

    task automatic test_r3_zero();
        press(4'b0011, 4'h5);
        checks++; if (r3 !== 4'h5) begin errors++; $display("FAIL r3_load got %h exp 5", r3); end
        press(4'b0011, 4'h0);
        checks++; if (r3 !== 4'h0) begin errors++; $display("FAIL r3_zero got %h exp 0", r3); end
        checks++; if (select !== 2'b00) begin errors++; $display("FAIL r3_select got %b exp 00", select); end
        instr = 4'b1111;
        repeat (10) @(negedge clk);
        checks++; if (select !== 2'b00) begin errors++; $display("FAIL select_hold got %b exp 00", select); end
        checks++; if (wr_count !== 4'h3) begin errors++; $display("FAIL r3_wrcount got %h exp 3", wr_count); end
    endtask

    task automatic test_rmw();
        press(4'b0011, 4'h7);
        fb_mode = 1'b1;
        press(4'b1011, 4'h0);
        checks++; if (r3 !== 4'h8) begin errors++; $display("FAIL rmw_r3 got %h exp 8", r3); end
        repeat (20) @(negedge clk);
        checks++; if (r3 !== 4'h8) begin errors++; $display("FAIL rmw_single got %h exp 8", r3); end
        checks++; if (wr_count !== 4'h5) begin errors++; $display("FAIL rmw_wrcount got %h exp 5", wr_count); end
        fb_mode = 1'b0;
    endtask

    task automatic test_hold();
        int waited = 0;
        @(negedge clk);
        instr  = 4'b0100;
        dp_val = 4'hA;
        step   = 1'b1;
        while (busy !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_start got busy %b exp 1", busy); end
        for (int i = 0; i < 50; i++) begin
            instr = (i % 2 == 0) ? 4'b1101 : 4'b0010;
            @(negedge clk);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy got %b exp 1", busy); end
        checks++; if (wr_count !== 4'h6) begin errors++; $display("FAIL hold_wrcount got %h exp 6", wr_count); end
        checks++; if ({r0, r1, r2, r3} !== 16'hA098) begin errors++; $display("FAIL hold_regs got %h exp a098", {r0, r1, r2, r3}); end
        step = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL release_busy got %b exp 1", busy); end
        repeat (SETTLE) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_idle got %b exp 0", busy); end
        checks++; if (select !== 2'b01) begin errors++; $display("FAIL hold_select got %b exp 01", select); end
        checks++; if (wr_count !== 4'h6) begin errors++; $display("FAIL hold_single got %h exp 6", wr_count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) press(4'b0001, i[3:0]);
        checks++; if (wr_count !== 4'h0) begin errors++; $display("FAIL wrap_wrcount got %h exp 0", wr_count); end
        checks++; if (r1 !== 4'h9) begin errors++; $display("FAIL wrap_r1 got %h exp 9", r1); end
    endtask

    task automatic test_reset_abort();
        int waited = 0;
        @(negedge clk);
        instr  = 4'b1000;
        dp_val = 4'hF;
        step   = 1'b1;
        while (busy !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_fetch got busy %b exp 1", busy); end
        rst_n = 1'b0;
        step  = 1'b0;
        #1;
        checks++; if ({select, r0, r1, r2, r3, wr_count, busy} !== 23'h0) begin errors++; $display("FAIL abort_outputs got %h exp 0", {select, r0, r1, r2, r3, wr_count, busy}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (SETTLE) @(negedge clk);
        checks++; if ({r0, r1, r2, r3, wr_count} !== 20'h0) begin errors++; $display("FAIL abort_nowrite got %h exp 0", {r0, r1, r2, r3, wr_count}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    endtask

    task automatic test_held_reset();
        logic seen_busy = 1'b0;
        rst_n  = 1'b0;
        instr  = 4'b0010;
        dp_val = 4'h3;
        step   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy === 1'b1) seen_busy = 1'b1;
        end
        checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL held_busy got %b exp 0", seen_busy); end
        checks++; if (wr_count !== 4'h0) begin errors++; $display("FAIL held_nowrite got %h exp 0", wr_count); end
        step = 1'b0;
        repeat (SETTLE) @(negedge clk);
        press(4'b0010, 4'h3);
        checks++; if (r2 !== 4'h3) begin errors++; $display("FAIL held_repress_r2 got %h exp 3", r2); end
        checks++; if (wr_count !== 4'h1) begin errors++; $display("FAIL held_repress_wrcount got %h exp 1", wr_count); end
    endtask

`ifdef STEP_DEBOUNCE_EN
    task automatic test_debounce();
        @(negedge clk);
        instr  = 4'b0000;
        dp_val = 4'hC;
        step   = 1'b1;
        repeat (10) @(negedge clk);
        step = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (wr_count !== 4'h1) begin errors++; $display("FAIL deb_short got %h exp 1", wr_count); end
        checks++; if (r0 !== 4'h0) begin errors++; $display("FAIL deb_short_r0 got %h exp 0", r0); end
        step = 1'b1;
        repeat (20) @(negedge clk);
        step = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (wr_count !== 4'h2) begin errors++; $display("FAIL deb_long got %h exp 2", wr_count); end
        checks++; if (r0 !== 4'hC) begin errors++; $display("FAIL deb_long_r0 got %h exp c", r0); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_r3_zero();
        test_rmw();
        test_hold();
        test_wrap();
        test_reset_abort();
        test_held_reset();
`ifdef STEP_DEBOUNCE_EN
        test_debounce();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
